// File: rtl/times_table_axi_reader.sv
// -----------------------------------------------------------------------------
// times_table_axi_reader
//
// Times-table lookup engine. Accepts an operand pair (a, b) on a valid/ready
// request port, issues a single AXI4-Lite read to a preloaded product table
// and returns the product with a one-cycle result strobe.
//
// Table layout: word index {a, b} (a in MSBs), byte address
// BASE_ADDR + ({a, b} << 2); each word holds a*b zero-extended.
//
// Optional feature macro: TT_SELFCHECK_EN
//   When defined, the latched operands are multiplied locally and compared
//   against the captured data; a difference raises chk_mismatch alongside
//   res_valid. This is intended for bring-up and simulation only.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous, active-high reset
//   req_valid/ready  request handshake; a, b are latched on acceptance
//   a, b           operands (OPW bits each)
//   res_valid      one-cycle strobe, result/res_err valid
//   result         product read from memory (2*OPW bits), held until next capture
//   res_err        RRESP was not OKAY, held until next capture
//   m_axi_ar*      AXI4-Lite read address channel (master side)
//   m_axi_r*       AXI4-Lite read data channel (master side)
//   chk_mismatch   (TT_SELFCHECK_EN only) local product differs from memory data
// -----------------------------------------------------------------------------
module times_table_axi_reader #(
  parameter int                OPW       = 3,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPW-1:0]    a,
  input  logic [OPW-1:0]    b,
  output logic              res_valid,
  output logic [2*OPW-1:0]  result,
  output logic              res_err,
`ifdef TT_SELFCHECK_EN
  output logic              chk_mismatch,
`endif
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [2*OPW-1:0]    result_q, result_d;
  logic                res_err_q, res_err_d;

  // Only the low 2*OPW data bits carry the product; the rest is ignored.
  logic                rdata_unused;
  assign rdata_unused = ^m_axi_rdata;

`ifdef TT_SELFCHECK_EN
  logic [OPW-1:0]      a_q, a_d;
  logic [OPW-1:0]      b_q, b_d;
  logic                chk_mismatch_q, chk_mismatch_d;
  logic [2*OPW-1:0]    local_product;

  assign local_product = (2*OPW)'(a_q) * (2*OPW)'(b_q);
`endif

  // NOTE: every variable written here gets its hold value first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    result_d  = result_q;
    res_err_d = res_err_q;
`ifdef TT_SELFCHECK_EN
    a_d            = a_q;
    b_d            = b_q;
    chk_mismatch_d = chk_mismatch_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // The address register doubles as the operand latch: later changes
          // on a/b cannot disturb the transaction in flight.
          araddr_d = BASE_ADDR + (ADDR_W'({a, b}) << 2);
`ifdef TT_SELFCHECK_EN
          a_d = a;
          b_d = b;
`endif
          state_d  = ADDR;
        end
      end

      ADDR: begin
        // arvalid is decoded from state, so it cannot drop before arready.
        if (m_axi_arready) state_d = DATA;
      end

      DATA: begin
        if (m_axi_rvalid) begin
          result_d  = m_axi_rdata[2*OPW-1:0];
          res_err_d = (m_axi_rresp != 2'b00);
`ifdef TT_SELFCHECK_EN
          chk_mismatch_d = (m_axi_rdata[2*OPW-1:0] != local_product);
`endif
          state_d   = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      result_q  <= '0;
      res_err_q <= 1'b0;
`ifdef TT_SELFCHECK_EN
      a_q            <= '0;
      b_q            <= '0;
      chk_mismatch_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      result_q  <= result_d;
      res_err_q <= res_err_d;
`ifdef TT_SELFCHECK_EN
      a_q            <= a_d;
      b_q            <= b_d;
      chk_mismatch_q <= chk_mismatch_d;
`endif
    end
  end

  // Handshake outputs are pure decodes of the state register: no path from
  // any AXI input reaches an AXI output within the same cycle.
  assign req_ready     = (state_q == IDLE);
  assign m_axi_arvalid = (state_q == ADDR);
  assign m_axi_rready  = (state_q == DATA);
  assign res_valid     = (state_q == DONE);
  assign m_axi_araddr  = araddr_q;
  assign result        = result_q;
  assign res_err       = res_err_q;
`ifdef TT_SELFCHECK_EN
  assign chk_mismatch  = chk_mismatch_q;
`endif

endmodule

// File: doc/times_table_axi_reader.md
# times_table_axi_reader

Parametrised times-table lookup engine. It accepts an operand pair (a, b) on a valid/ready request port, issues one AXI4-Lite read to a preloaded product memory (block RAM with an AXI4-Lite slave), and returns the product with a one-cycle result strobe. It replaces the fixed 3-bit lookup. Operand width is generalised, and it adds full AR/R handshaking, operand latching, response-error reporting and optional self-checking.

## Interface
Parameters:
- OPW, 3, operand width in bits; the table covers (0..2^OPW-1) x (0..2^OPW-1)
- ADDR_W, 32, AXI address width; must satisfy ADDR_W >= 2*OPW+2
- DATA_W, 32, AXI read data width; must satisfy DATA_W >= 2*OPW
- BASE_ADDR, 0, byte base address of the table in the memory map

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  engine can accept a request
- a  in  OPW  multiplicand
- b  in  OPW  multiplier
- res_valid  out  1  one-cycle strobe: result/res_err valid
- result  out  2*OPW  product read from memory
- res_err  out  1  RRESP was not OKAY (2'b00)
- m_axi_araddr  out  ADDR_W  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  DATA_W  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready

## Operation
- Table layout: word index {a,b} (a in MSBs); byte address = BASE_ADDR + ({a,b} << 2). Memory word holds a*b zero-extended.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: req_ready=1. On req_valid, latch a and b, compute araddr, go to ADDR. Later changes on a and b are ignored.
- ADDR: arvalid=1 with araddr stable. Once asserted, arvalid is never dropped before arready (AXI rule). On arready, go to DATA.
- DATA: rready=1. On rvalid, capture rdata[2*OPW-1:0] into result, set res_err = (rresp != 2'b00), go to DONE. Upper rdata bits are ignored.
- DONE: res_valid=1 for exactly one cycle, then IDLE. result and res_err hold their values until the next capture.
- req_ready is 0 in ADDR, DATA and DONE. Exactly one outstanding transaction exists at any time.
- An rvalid arriving in IDLE or ADDR is ignored, because rready=0 there.
- Reset (any state, including mid-transaction): state=IDLE. arvalid=0, rready=0, res_valid=0, result=0, res_err=0, req_ready=1 from the cycle after reset deasserts. The memory's own reset is driven from the same rst (inverted to aresetn) at top level, so no orphan response survives.

## Timing
- Cycle 0: request accepted (req_valid & req_ready).
- Cycle 1: arvalid=1. If arready=1 here, DATA from cycle 2.
- Cycle 2: rready=1. If rvalid=1 here, res_valid=1 in cycle 3.
- Minimum latency is 3 cycles from acceptance to res_valid. Each arready/rvalid stall adds 1 cycle.
- The earliest next acceptance is the cycle after res_valid, giving a throughput of 1 request per 4 cycles.
- Every output is registered. There are no combinational paths from AXI inputs to AXI outputs.

## Configuration
- TT_SELFCHECK_EN defined: the latched operands are multiplied locally (2*OPW-bit product). A mismatch against the captured data raises an extra output, chk_mismatch (1 bit), together with res_valid. That output resets to 0 and is held until the next capture. The self-check is only for bring-up and simulation.
- TT_SELFCHECK_EN undefined: no multiplier and no chk_mismatch port. The block uses only the memory lookup.

## Test plan
- OPW=3, memory word k = (k>>3)*(k&7), arready/rvalid tied high; a=5, b=7 -> araddr=0x000000BC, res_valid in cycle 3, result=35, res_err=0.
- a=0, b=0, then a=7, b=7 back-to-back -> araddr 0x00 then 0xFC; results 0 and 49; req_ready low during the first transaction.
- arready held low 4 cycles, rvalid delayed 3 cycles, and a/b changed after acceptance -> arvalid and araddr stable throughout, result uses the latched operands, latency = 3+7 cycles.
- Slave returns rresp=2'b10 for a=3, b=4 -> res_valid=1, res_err=1, result=12 (data still captured).
- rst pulsed while in DATA -> next cycle arvalid=0, rready=0, result=0, req_ready=1; a new request a=2, b=6 then completes with 12.
- TT_SELFCHECK_EN defined, word for a=6, b=6 corrupted to 35 -> result=35, chk_mismatch=1; correct word 36 -> chk_mismatch=0.
